// File: rtl/dac_wave_sequencer.sv
// dac_wave_sequencer: tick-paced phase-accumulator waveform generator feeding
// the 8-bit DAC (I_data/en). Supports sine, square, sawtooth and triangle
// waves with amplitude scaling about midscale. Configuration changes made
// while running are staged in a shadow register and applied on an
// accumulator wrap, so they never land mid-period. Starting and stopping are
// glitch-free, and a stop always ends with a midscale sample.
// Optional build macro DAC_WAVE_SEQUENCER_SAMPLE_CNT_EN adds the sample_cnt
// and wrap_cnt outputs.
module dac_wave_sequencer #(
    parameter int         PHASE_W  = 16,
    parameter logic [7:0] MIDSCALE = 8'h80
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [1:0]         cfg_wave,
    input  logic [7:0]         cfg_amp,
    output logic [7:0]         dac_data,
    output logic               dac_en,
    output logic               busy
`ifdef DAC_WAVE_SEQUENCER_SAMPLE_CNT_EN
    ,
    output logic [15:0]        sample_cnt,
    output logic [7:0]         wrap_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPING
    } state_t;

    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_SAW    = 2'd2;
    localparam logic [1:0] WAVE_TRI    = 2'd3;

    // Quarter-wave table: round(127.5 * sin(pi * (2i + 1) / 256)), i = 0..63.
    localparam logic [6:0] SINE_LUT [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd36,  7'd39,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd59,  7'd61,  7'd64,  7'd67,  7'd70,
        7'd72,  7'd75,  7'd77,  7'd80,  7'd82,  7'd84,  7'd87,  7'd89,
        7'd91,  7'd93,  7'd96,  7'd98,  7'd100, 7'd101, 7'd103, 7'd105,
        7'd107, 7'd109, 7'd110, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117,
        7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125,
        7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127
    };

    // Raw 8-bit code for the selected waveform at phase byte p8.
    function automatic logic [7:0] wave_raw(input logic [1:0] wave, input logic [7:0] p8);
        logic [5:0] idx;
        logic [6:0] lut;
        // Odd quadrants walk the table backwards: 63 - i is ~i on 6 bits.
        idx = p8[6] ? ~p8[5:0] : p8[5:0];
        lut = SINE_LUT[idx];
        case (wave)
            WAVE_SINE:   wave_raw = p8[7] ? (8'd127 - {1'b0, lut}) : (8'd128 + {1'b0, lut});
            WAVE_SQUARE: wave_raw = p8[7] ? 8'h00 : 8'hFF;
            WAVE_SAW:    wave_raw = p8;
            WAVE_TRI:    wave_raw = p8[7] ? 8'(9'd511 - {p8, 1'b0}) : {p8[6:0], 1'b0};
            default:     wave_raw = p8;
        endcase
    endfunction

    // Scale raw code about midscale; full-scale amplitude passes through.
    // The true result always fits in 8 bits, so modulo-256 arithmetic is exact.
    function automatic logic [7:0] amp_scale(input logic [7:0] r, input logic [7:0] amp);
        if (amp == 8'hFF) begin
            amp_scale = r;
        end else begin
            amp_scale = 8'((16'(r) * 16'(amp)) >> 8) + 8'd128 - {1'b0, amp[7:1]};
        end
    endfunction

    state_t             state;
    state_t             state_nxt;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W:0]   phase_sum;
    logic               wrap;
    logic [7:0]         p8;

    logic [PHASE_W-1:0] act_ftw;
    logic [1:0]         act_wave;
    logic [7:0]         act_amp;

    logic               sh_full;
    logic [PHASE_W-1:0] sh_ftw;
    logic [1:0]         sh_wave;
    logic [7:0]         sh_amp;

    logic               cfg_fire;

    assign phase_sum = {1'b0, phase} + {1'b0, act_ftw};
    assign wrap      = phase_sum[PHASE_W];
    assign p8        = phase[PHASE_W-1 -: 8];
    assign cfg_fire  = cfg_valid & cfg_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus handshake/busy decode.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                cfg_ready = ~sh_full;
                if (stop) begin
                    state_nxt = S_STOPPING;
                end
            end
            S_STOPPING: begin
                busy = 1'b1;
                if (tick) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Accumulator, active config, shadow-valid flag and DAC output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            act_ftw  <= '0;
            act_wave <= WAVE_SINE;
            act_amp  <= 8'hFF;
            sh_full  <= 1'b0;
            dac_data <= MIDSCALE;
            dac_en   <= 1'b0;
        end else begin
            dac_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    sh_full <= 1'b0;
                    if (cfg_fire) begin
                        act_ftw  <= cfg_ftw;
                        act_wave <= cfg_wave;
                        act_amp  <= cfg_amp;
                    end
                    if (start) begin
                        phase <= '0;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        dac_data <= amp_scale(wave_raw(act_wave, p8), act_amp);
                        dac_en   <= 1'b1;
                        phase    <= phase_sum[PHASE_W-1:0];
                        // A staged config only lands on a period boundary.
                        if (wrap && sh_full) begin
                            act_ftw  <= sh_ftw;
                            act_wave <= sh_wave;
                            act_amp  <= sh_amp;
                            sh_full  <= 1'b0;
                        end
                    end
                    // cfg_ready is low while the shadow is full, so this never
                    // collides with the copy above.
                    if (cfg_fire) begin
                        sh_full <= 1'b1;
                    end
                end
                S_STOPPING: begin
                    if (tick) begin
                        dac_data <= MIDSCALE;
                        dac_en   <= 1'b1;
                        sh_full  <= 1'b0;
                    end
                end
                default: begin
                    sh_full <= 1'b0;
                end
            endcase
        end
    end

    // Shadow config payload; its validity is carried by sh_full.
    always_ff @(posedge clk) begin
        if (state == S_RUN && cfg_fire) begin
            sh_ftw  <= cfg_ftw;
            sh_wave <= cfg_wave;
            sh_amp  <= cfg_amp;
        end
    end

`ifdef DAC_WAVE_SEQUENCER_SAMPLE_CNT_EN
    logic emit;
    assign emit = tick && (state == S_RUN || state == S_STOPPING);

    // Saturating increment for the wrap counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Count every DAC strobe, including the final midscale one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (emit) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

    // Count accumulator wraps while running; restart from zero on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            wrap_cnt <= '0;
        end else if (state == S_RUN && tick && wrap) begin
            wrap_cnt <= sat_inc8(wrap_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// Self-checking bench for dac_wave_sequencer: table-driven waveform vectors
// plus hand-written sequences for shadow config, stop, and reset corners.
// Expected DAC samples are queued when a tick is driven and checked when
// dac_en appears.
module tb_dac_wave_sequencer;

    localparam logic [7:0] MID = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        start;
    logic        stop;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_ftw;
    logic [1:0]  cfg_wave;
    logic [7:0]  cfg_amp;
    logic [7:0]  dac_data;
    logic        dac_en;
    logic        busy;
`ifdef DAC_WAVE_SEQUENCER_SAMPLE_CNT_EN
    logic [15:0] sample_cnt;
    logic [7:0]  wrap_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       tick_emit = 1'b0;
    logic       exp_en = 1'b0;

    typedef struct {
        logic [1:0]       wave;
        logic [7:0]       amp;
        logic [15:0]      ftw;
        logic [0:3][7:0]  smp;
    } vec_t;

    vec_t tbl[9];

    dac_wave_sequencer #(.PHASE_W(16), .MIDSCALE(8'h80)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ftw   (cfg_ftw),
        .cfg_wave  (cfg_wave),
        .cfg_amp   (cfg_amp),
        .dac_data  (dac_data),
        .dac_en    (dac_en),
        .busy      (busy)
`ifdef DAC_WAVE_SEQUENCER_SAMPLE_CNT_EN
        ,
        .sample_cnt(sample_cnt),
        .wrap_cnt  (wrap_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic emit, input logic [7:0] val);
        if (emit) exp_q.push_back(val);
        tick      = 1'b1;
        tick_emit = emit;
        step();
        tick      = 1'b0;
        tick_emit = 1'b0;
    endtask

    task automatic load_cfg(input logic [1:0] w, input logic [15:0] f, input logic [7:0] a);
        cfg_wave  = w;
        cfg_ftw   = f;
        cfg_amp   = a;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic stop_and_drain();
        stop = 1'b1;
        step();
        stop = 1'b0;
        do_tick(1'b1, MID);
        chk("busy_after_stop", 16'(busy), 16'd0);
    endtask

    // The DUT sees tick at this edge; its strobe must follow one cycle later.
    always @(posedge clk) exp_en <= tick_emit;

    // Scoreboard: pop and compare on each strobe, and check strobe timing.
    always @(negedge clk) begin
        if (dac_en !== 1'b0 || exp_en) begin
            chk("dac_en_latency", 16'(dac_en), 16'(exp_en));
            if (dac_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %h expected no strobe", dac_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("dac_data", 16'(dac_data), 16'(mon_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // wave, amp, ftw, first four samples from phase 0
        tbl[0] = '{wave: 2'd2, amp: 8'hFF, ftw: 16'h1000, smp: {8'h00, 8'h10, 8'h20, 8'h30}};
        tbl[1] = '{wave: 2'd0, amp: 8'hFF, ftw: 16'h4000, smp: {8'h82, 8'hFF, 8'h7D, 8'h00}};
        tbl[2] = '{wave: 2'd0, amp: 8'h80, ftw: 16'h4000, smp: {8'h81, 8'hBF, 8'h7E, 8'h40}};
        tbl[3] = '{wave: 2'd1, amp: 8'hFF, ftw: 16'h4000, smp: {8'hFF, 8'hFF, 8'h00, 8'h00}};
        tbl[4] = '{wave: 2'd3, amp: 8'hFF, ftw: 16'h4000, smp: {8'h00, 8'h80, 8'hFF, 8'h7F}};
        tbl[5] = '{wave: 2'd2, amp: 8'h40, ftw: 16'h4000, smp: {8'h60, 8'h70, 8'h80, 8'h90}};
        tbl[6] = '{wave: 2'd1, amp: 8'h00, ftw: 16'h4000, smp: {8'h80, 8'h80, 8'h80, 8'h80}};
        tbl[7] = '{wave: 2'd3, amp: 8'hFE, ftw: 16'h2000, smp: {8'h01, 8'h40, 8'h80, 8'hBF}};
        tbl[8] = '{wave: 2'd0, amp: 8'hFF, ftw: 16'h0400, smp: {8'h82, 8'h8E, 8'h9A, 8'hA7}};

        rst = 1'b1; start = 1'b1; stop = 1'b0; tick = 1'b0;
        cfg_valid = 1'b0; cfg_ftw = '0; cfg_wave = '0; cfg_amp = '0;

        // Reset dominates a held start.
        repeat (3) step();
        chk("rst_dac_data", 16'(dac_data), 16'h0080);
        chk("rst_dac_en", 16'(dac_en), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_cfg_ready", 16'(cfg_ready), 16'd1);
        rst = 1'b0; start = 1'b0;
        do_tick(1'b0, 8'h00);
        chk("idle_tick_busy", 16'(busy), 16'd0);
        chk("idle_dac_data", 16'(dac_data), 16'h0080);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 16'(busy), 16'd1);
        stop_and_drain();

        // Waveform and amplitude table.
        for (int v = 0; v < 9; v++) begin
            load_cfg(tbl[v].wave, tbl[v].ftw, tbl[v].amp);
            start = 1'b1;
            step();
            start = 1'b0;
            for (int k = 0; k < 4; k++) do_tick(1'b1, tbl[v].smp[k]);
            stop_and_drain();
        end

        // Long sawtooth run crosses the accumulator wrap.
        load_cfg(2'd2, 16'h1000, 8'hFF);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) do_tick(1'b1, 8'((k * 16) % 256));
        stop_and_drain();

        // Shadow config applies only after a wrap; a second offer waits.
        load_cfg(2'd2, 16'h4000, 8'hFF);
        start = 1'b1;
        step();
        start = 1'b0;
        do_tick(1'b1, 8'h00);
        do_tick(1'b1, 8'h40);
        cfg_wave = 2'd2; cfg_ftw = 16'h8000; cfg_amp = 8'hFF; cfg_valid = 1'b1;
        chk("ready_run_empty", 16'(cfg_ready), 16'd1);
        step();
        chk("ready_after_hs", 16'(cfg_ready), 16'd0);
        cfg_ftw = 16'h2000;
        step();
        chk("ready_held_off", 16'(cfg_ready), 16'd0);
        do_tick(1'b1, 8'h80);
        chk("ready_before_wrap", 16'(cfg_ready), 16'd0);
        do_tick(1'b1, 8'hC0);
        chk("ready_after_wrap", 16'(cfg_ready), 16'd1);
        do_tick(1'b1, 8'h00);
        cfg_valid = 1'b0;
        chk("ready_second_hs", 16'(cfg_ready), 16'd0);
        do_tick(1'b1, 8'h80);
        do_tick(1'b1, 8'h00);
        do_tick(1'b1, 8'h20);
        do_tick(1'b1, 8'h40);

        // Stop together with a tick still emits that sample first.
        stop = 1'b1;
        do_tick(1'b1, 8'h60);
        stop = 1'b0;
        chk("stopping_busy", 16'(busy), 16'd1);
        chk("stopping_ready", 16'(cfg_ready), 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored_stopping", 16'(busy), 16'd1);
        do_tick(1'b1, MID);
        chk("idle_after_drain", 16'(busy), 16'd0);
        do_tick(1'b0, 8'h00);
        do_tick(1'b0, 8'h00);

        // Simultaneous start and stop in idle: start wins.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("start_wins_busy", 16'(busy), 16'd1);
        stop_and_drain();

        // Reset mid-run: no drain sample, defaults restored.
        load_cfg(2'd1, 16'h4000, 8'h40);
        start = 1'b1;
        step();
        start = 1'b0;
        do_tick(1'b1, 8'h9F);
        chk("pre_reset_data", 16'(dac_data), 16'h009F);
        rst = 1'b1;
        do_tick(1'b0, 8'h00);
        chk("midrun_rst_data", 16'(dac_data), 16'h0080);
        chk("midrun_rst_en", 16'(dac_en), 16'd0);
        chk("midrun_rst_busy", 16'(busy), 16'd0);
        chk("midrun_rst_ready", 16'(cfg_ready), 16'd1);
`ifdef DAC_WAVE_SEQUENCER_SAMPLE_CNT_EN
        chk("midrun_rst_sample_cnt", sample_cnt, 16'd0);
        chk("midrun_rst_wrap_cnt", 16'(wrap_cnt), 16'd0);
`endif
        rst = 1'b0;
        // Defaults: sine, ftw 0, full amplitude -> phase stays 0.
        start = 1'b1;
        step();
        start = 1'b0;
        do_tick(1'b1, 8'h82);
        do_tick(1'b1, 8'h82);
        stop_and_drain();

        step();
        step();
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
